// File: rtl/spi_ip_xfer_ctrl.sv
// SPI master transfer sequencer: chip-select setup, N-bit shift, chip-select hold.
// Optional abort input enabled by defining SPI_IP_XFER_CTRL_ABORT_EN.
module spi_ip_xfer_ctrl #(
   parameter int DATA_WIDTH     = 32,
   parameter int LEN_WIDTH      = 5,
   parameter int CS_SETUP_TICKS = 2,
   parameter int CS_HOLD_TICKS  = 2
) (
   input  logic                  xc_clk_i,
   input  logic                  xc_rst_i,
   input  logic                  xc_start_i,
   input  logic [DATA_WIDTH-1:0] xc_tx_data_i,
   input  logic [LEN_WIDTH-1:0]  xc_len_i,
   input  logic                  xc_lsb_first_i,
   input  logic                  xc_tick_i,
   input  logic                  xc_tick_launch_i,
   input  logic                  xc_tick_capture_i,
   input  logic                  xc_miso_i,
`ifdef SPI_IP_XFER_CTRL_ABORT_EN
   input  logic                  xc_abort_i,
`endif
   output logic                  xc_en_tick_o,
   output logic                  xc_en_sck_o,
   output logic                  xc_en_lc_o,
   output logic                  xc_cs_n_o,
   output logic                  xc_mosi_o,
   output logic [DATA_WIDTH-1:0] xc_rx_data_o,
   output logic                  xc_busy_o,
   output logic                  xc_done_o
);

   localparam int TICK_MAX = (CS_SETUP_TICKS > CS_HOLD_TICKS) ? CS_SETUP_TICKS : CS_HOLD_TICKS;
   localparam int TCW      = $clog2(TICK_MAX + 1);
   localparam int CCW      = LEN_WIDTH + 1;
   localparam logic [TCW-1:0] SETUP_LAST = TCW'(CS_SETUP_TICKS - 1);
   localparam logic [TCW-1:0] HOLD_LAST  = TCW'(CS_HOLD_TICKS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_HOLD,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] tx_q, tx_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic                  lsb_q, lsb_d;
   logic [TCW-1:0]        tick_cnt_q, tick_cnt_d;
   logic [CCW-1:0]        cap_cnt_q, cap_cnt_d;
   logic [DATA_WIDTH-1:0] rx_q, rx_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  mosi_q, mosi_d;
   logic                  cs_n_q, cs_n_d;
   logic                  en_tick_q, en_tick_d;
   logic                  en_sck_q, en_sck_d;
   logic                  en_lc_q, en_lc_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [LEN_WIDTH-1:0]  bit_idx;
   logic                  abort;

`ifdef SPI_IP_XFER_CTRL_ABORT_EN
   assign abort = xc_abort_i;
`else
   assign abort = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      tx_d       = tx_q;
      len_d      = len_q;
      lsb_d      = lsb_q;
      tick_cnt_d = tick_cnt_q;
      cap_cnt_d  = cap_cnt_q;
      rx_d       = rx_q;
      rx_data_d  = rx_data_q;
      mosi_d     = mosi_q;
      // The next bit to launch is indexed by how many bits have been captured so far.
      bit_idx    = lsb_q ? cap_cnt_q[LEN_WIDTH-1:0] : (len_q - cap_cnt_q[LEN_WIDTH-1:0]);

      case (state_q)
         S_IDLE: begin
            if (xc_start_i) begin
               tx_d       = xc_tx_data_i;
               len_d      = xc_len_i;
               lsb_d      = xc_lsb_first_i;
               mosi_d     = xc_lsb_first_i ? xc_tx_data_i[0] : xc_tx_data_i[xc_len_i];
               tick_cnt_d = '0;
               cap_cnt_d  = '0;
               rx_d       = '0;
               state_d    = S_SETUP;
            end
         end
         S_SETUP: begin
            if (xc_tick_i) begin
               if (tick_cnt_q == SETUP_LAST) state_d = S_SHIFT;
               else                          tick_cnt_d = tick_cnt_q + TCW'(1);
            end
         end
         S_SHIFT: begin
            if (xc_tick_capture_i) begin
               // LSB-first bits drop straight into their final position; MSB-first shift in.
               if (lsb_q) rx_d[cap_cnt_q[LEN_WIDTH-1:0]] = xc_miso_i;
               else       rx_d = {rx_q[DATA_WIDTH-2:0], xc_miso_i};
               cap_cnt_d = cap_cnt_q + CCW'(1);
               if (cap_cnt_q == {1'b0, len_q}) begin
                  tick_cnt_d = '0;
                  state_d    = S_HOLD;
               end
            end else if (xc_tick_launch_i && (cap_cnt_q != '0)) begin
               mosi_d = tx_q[bit_idx];
            end
         end
         S_HOLD: begin
            if (xc_tick_i) begin
               if (tick_cnt_q == HOLD_LAST) begin
                  rx_data_d = rx_q;
                  state_d   = S_DONE;
               end else begin
                  tick_cnt_d = tick_cnt_q + TCW'(1);
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (abort && ((state_q == S_SETUP) || (state_q == S_SHIFT))) begin
         tick_cnt_d = '0;
         state_d    = S_HOLD;
      end

      // Outputs follow the next state so they are registered alongside it.
      cs_n_d    = (state_d == S_IDLE) || (state_d == S_DONE);
      en_tick_d = (state_d == S_SETUP) || (state_d == S_SHIFT) || (state_d == S_HOLD);
      en_sck_d  = (state_d == S_SHIFT);
      en_lc_d   = (state_d == S_SHIFT);
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_DONE);
   end

   always_ff @(posedge xc_clk_i) begin
      if (xc_rst_i) begin
         state_q    <= S_IDLE;
         tx_q       <= '0;
         len_q      <= '0;
         lsb_q      <= 1'b0;
         tick_cnt_q <= '0;
         cap_cnt_q  <= '0;
         rx_q       <= '0;
         rx_data_q  <= '0;
         mosi_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         en_tick_q  <= 1'b0;
         en_sck_q   <= 1'b0;
         en_lc_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_q       <= tx_d;
         len_q      <= len_d;
         lsb_q      <= lsb_d;
         tick_cnt_q <= tick_cnt_d;
         cap_cnt_q  <= cap_cnt_d;
         rx_q       <= rx_d;
         rx_data_q  <= rx_data_d;
         mosi_q     <= mosi_d;
         cs_n_q     <= cs_n_d;
         en_tick_q  <= en_tick_d;
         en_sck_q   <= en_sck_d;
         en_lc_q    <= en_lc_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign xc_en_tick_o = en_tick_q;
   assign xc_en_sck_o  = en_sck_q;
   assign xc_en_lc_o   = en_lc_q;
   assign xc_cs_n_o    = cs_n_q;
   assign xc_mosi_o    = mosi_q;
   assign xc_rx_data_o = rx_data_q;
   assign xc_busy_o    = busy_q;
   assign xc_done_o    = done_q;

endmodule

// File: tb/tb_spi_ip_xfer_ctrl.sv
// Testbench for spi_ip_xfer_ctrl: a small tick-generator model, a MISO source,
// and table-driven transfers plus reset/abort sequences.
module tb_spi_ip_xfer_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] txData;
   logic [4:0]  len;
   logic        lsbFirst;
   logic        tick, tickLaunch, tickCap;
   logic        miso;
   logic        abort;
   logic        enTick, enSck, enLc, csN, mosi, busy, done;
   logic [31:0] rxData;

   always #5 clock = ~clock;

   spi_ip_xfer_ctrl dut (
      .xc_clk_i          (clock),
      .xc_rst_i          (reset),
      .xc_start_i        (start),
      .xc_tx_data_i      (txData),
      .xc_len_i          (len),
      .xc_lsb_first_i    (lsbFirst),
      .xc_tick_i         (tick),
      .xc_tick_launch_i  (tickLaunch),
      .xc_tick_capture_i (tickCap),
      .xc_miso_i         (miso),
`ifdef SPI_IP_XFER_CTRL_ABORT_EN
      .xc_abort_i        (abort),
`endif
      .xc_en_tick_o      (enTick),
      .xc_en_sck_o       (enSck),
      .xc_en_lc_o        (enLc),
      .xc_cs_n_o         (csN),
      .xc_mosi_o         (mosi),
      .xc_rx_data_o      (rxData),
      .xc_busy_o         (busy),
      .xc_done_o         (done)
   );

   // Tick generator model: one tick every other cycle; capture on the first tick of each sck period.
   logic divQ, phaseQ;
   always @(posedge clock) begin
      if (reset) begin
         divQ   <= 1'b0;
         phaseQ <= 1'b0;
      end else begin
         divQ <= enTick ? ~divQ : 1'b0;
         if (!enLc)     phaseQ <= 1'b0;
         else if (tick) phaseQ <= ~phaseQ;
      end
   end
   assign tick       = enTick & divQ;
   assign tickCap    = tick & enLc & ~phaseQ;
   assign tickLaunch = tick & enLc & phaseQ;

   // Slave model and transfer monitor.
   logic [31:0] curWord;
   int          curLen;
   logic        curLsb, curLoop;
   logic        monClr;
   int          monCaps, monTicks, monDone, misoIdx;
   logic [31:0] monMosi;

   always_comb begin
      misoIdx = curLsb ? monCaps : (curLen - monCaps);
      if (curLoop)                          miso = mosi;
      else if (misoIdx >= 0 && misoIdx < 32) miso = curWord[misoIdx];
      else                                   miso = 1'b0;
   end

   always @(posedge clock) begin
      if (monClr) begin
         monCaps  <= 0;
         monTicks <= 0;
         monDone  <= 0;
         monMosi  <= '0;
      end else begin
         if (tickCap) begin
            monCaps <= monCaps + 1;
            if (curLsb) begin
               if (monCaps < 32) monMosi[monCaps] <= mosi;
            end else begin
               monMosi <= {monMosi[30:0], mosi};
            end
         end
         if (tick && !csN && !enSck) monTicks <= monTicks + 1;
         if (done) monDone <= monDone + 1;
      end
   end

   typedef struct {
      logic [31:0] tx;
      logic [4:0]  len;
      logic        lsb;
      logic [31:0] misoWord;
      logic        loopBack;
      logic        midStart;
      logic [31:0] expRx;
      logic [31:0] expMosi;
   } vec_t;

   vec_t vecs[6];
   int   checks = 0;
   int   passes = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge clock);
      curWord  = v.misoWord;
      curLen   = int'(v.len);
      curLsb   = v.lsb;
      curLoop  = v.loopBack;
      txData   = v.tx;
      len      = v.len;
      lsbFirst = v.lsb;
      start    = 1'b1;
      monClr   = 1'b1;
      @(negedge clock);
      start  = 1'b0;
      monClr = 1'b0;
      if (v.midStart) begin
         repeat (30) @(negedge clock);
         txData = 32'h0;
         len    = 5'd0;
         start  = 1'b1;
         @(negedge clock);
         start = 1'b0;
      end
   endtask

   task automatic waitCaps(input int n);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clock);
         if (monCaps >= n) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) checkOutput("capture wait timeout", 32'(monCaps), 32'(n));
   endtask

   task automatic finishXfer(input string name, input logic [31:0] expRx,
                             input logic [31:0] expMosi, input int expCaps);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput({name, " done seen"}, 32'(seen), 32'd1);
      checkOutput({name, " rx_data"}, rxData, expRx);
      checkOutput({name, " mosi bits"}, monMosi, expMosi);
      checkOutput({name, " captures"}, 32'(monCaps), 32'(expCaps));
      checkOutput({name, " cs setup+hold ticks"}, 32'(monTicks), 32'd4);
      @(negedge clock);
      checkOutput({name, " idle {busy,done,cs_n}"}, {29'd0, busy, done, csN}, 32'd1);
      repeat (6) @(negedge clock);
      checkOutput({name, " done count / no requeue"}, {monDone[30:0], busy}, 32'd2);
   endtask

   initial begin
      // {tx, len, lsb, misoWord, loop, midStart, expRx, expMosi}
      vecs[0] = '{32'h000000A5, 5'd7,  1'b0, 32'h0000003C, 1'b0, 1'b0, 32'h0000003C, 32'h000000A5};
      vecs[1] = '{32'h00000001, 5'd0,  1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000001, 32'h00000001};
      vecs[2] = '{32'hDEADBEEF, 5'd31, 1'b1, 32'h00000000, 1'b1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[3] = '{32'h00000005, 5'd3,  1'b0, 32'h00000009, 1'b0, 1'b0, 32'h00000009, 32'h00000005};
      vecs[4] = '{32'h12345678, 5'd15, 1'b1, 32'h0000ABCD, 1'b0, 1'b0, 32'h0000ABCD, 32'h00005678};
      vecs[5] = '{32'h80000001, 5'd31, 1'b0, 32'hC0000003, 1'b0, 1'b0, 32'hC0000003, 32'h80000001};

      curWord = '0; curLen = 0; curLsb = 1'b0; curLoop = 1'b0;
      monClr = 1'b1; abort = 1'b0;
      reset = 1'b1; start = 1'b1; txData = 32'hFFFFFFFF; len = 5'd7; lsbFirst = 1'b0;

      // Reset held with start high: nothing may begin.
      repeat (3) @(negedge clock);
      checkOutput("reset cs_n", {31'd0, csN}, 32'd1);
      checkOutput("reset en_tick", {31'd0, enTick}, 32'd0);
      checkOutput("reset en_sck", {31'd0, enSck}, 32'd0);
      checkOutput("reset en_lc", {31'd0, enLc}, 32'd0);
      checkOutput("reset mosi", {31'd0, mosi}, 32'd0);
      checkOutput("reset busy", {31'd0, busy}, 32'd0);
      checkOutput("reset done", {31'd0, done}, 32'd0);
      checkOutput("reset rx_data", rxData, 32'd0);
      reset = 1'b0;
      start = 1'b0;
      monClr = 1'b0;
      repeat (8) @(negedge clock);
      checkOutput("post-reset idle {busy,cs_n}", {30'd0, busy, csN}, 32'd1);

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i]);
         finishXfer($sformatf("vec%0d", i), vecs[i].expRx, vecs[i].expMosi, int'(vecs[i].len) + 1);
      end

      // Reset at the 4th capture of an 8-bit transfer, then a clean rerun.
      applyStimulus(vecs[0]);
      waitCaps(4);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("midreset cs_n", {31'd0, csN}, 32'd1);
      checkOutput("midreset en_*", {29'd0, enTick, enSck, enLc}, 32'd0);
      checkOutput("midreset busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      @(negedge clock);
      applyStimulus(vecs[0]);
      finishXfer("rerun", 32'h0000003C, 32'h000000A5, 8);

`ifdef SPI_IP_XFER_CTRL_ABORT_EN
      // Abort after 3 captures of MSB-first 0xA0: bits 1,0,1 were received.
      applyStimulus('{32'h000000A5, 5'd7, 1'b0, 32'h000000A0, 1'b0, 1'b0, 32'h5, 32'h5});
      waitCaps(3);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      finishXfer("abort", 32'h00000005, 32'h00000005, 3);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
